adder_share_ctrl: RTL and testbench

Controller that time-shares one instance of the team's 32-bit registered-carry adder (rdcla) between NREQ requesters.
- The adder's sum XORs the current a^b with carries registered several stages earlier, so a result is valid only if a/b/cin are held stable for at least SETTLE cycles.
- This block arbitrates round-robin, latches and holds the operands, counts out the settle time, captures sum/cout and returns them to the winning requester over a valid/ready response.
- It sits between the FP multiplier's mantissa/exponent users and the shared adder.

---
 rtl/adder_share_ctrl_pkg.sv | 19 +
 rtl/adder_share_ctrl_rr_arbiter.sv | 36 +++
 rtl/adder_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the adder-sharing controller.
//   state_e : controller FSM states (IDLE, WAIT, RESP)
//   DATA_W  : operand / sum width of the shared adder
//   idx_w() : index width for an n-entry vector (at least 1 bit)
package adder_share_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index; search runs upward from here with wrap
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted requester
//   any : at least one request present
module adder_share_ctrl_rr_arbiter
    import adder_share_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int k;
        k   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one registered-carry adder between NREQ requesters.
// A round-robin winner's operands are latched onto add_a/add_b/add_cin and
// held for SETTLE cycles so the adder's registered carries catch up; then
// sum/cout are captured and returned over a one-hot valid/ready response.
//
// Handshake semantics: a request transfers on an edge where req_valid[i] and
// req_ready[i] are both high; a response transfers on an edge where
// rsp_valid[i] and rsp_ready[i] are both high. ready may depend
// combinationally on valid; valid never depends on ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_a/req_b/req_cin   packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_sum/rsp_cout      captured result (shared bus)
//   add_a/add_b/add_cin   registered operands to the shared adder
//   add_sum/add_cout      result from the shared adder
//   busy                  high in WAIT and RESP
//   grant_id              index of current/last grantee
//   op_count              completed responses, wraps
//   state_dbg             current FSM state
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 6,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_a,
    input  logic [NREQ*DATA_W-1:0]    req_b,
    input  logic [NREQ-1:0]           req_cin,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_cout,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    output logic                      add_cin,
    input  logic [DATA_W-1:0]         add_sum,
    input  logic                      add_cout,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [CNT_W-1:0]          op_count,
    output state_e                    state_dbg
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = idx_w(SETTLE);

    state_e          state;
    state_e          state_nxt;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic            accept;
    logic            capture;
    logic            handshake;

    adder_share_ctrl_rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // rst_n gates the accept so req_ready reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_any && rst_n) begin
                    req_ready = arb_gnt;
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (rsp_ready[grant_id]) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            ptr      <= '0;
            grant_id <= '0;
            op_count <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            // Counter loads SETTLE-1 on accept and reaches 0 after SETTLE-1
            // decrements, so capture lands exactly SETTLE edges after accept.
            if (accept) begin
                add_a    <= req_a[arb_idx*DATA_W +: DATA_W];
                add_b    <= req_b[arb_idx*DATA_W +: DATA_W];
                add_cin  <= req_cin[arb_idx];
                grant_id <= arb_idx;
                cnt      <= CW'(SETTLE - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
            end
            // Priority rotates only once the response is taken.
            if (handshake) begin
                op_count <= op_count + 1'b1;
                ptr      <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;
    import adder_share_ctrl_pkg::*;

    localparam int N      = 4;
    localparam int SETTLE = 6;
    localparam int CNT_W  = 4;
    localparam int HD     = SETTLE - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*32-1:0]     req_a;
    logic [N*32-1:0]     req_b;
    logic [N-1:0]        req_cin;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;
    logic [31:0]         add_a;
    logic [31:0]         add_b;
    logic                add_cin;
    logic [31:0]         add_sum;
    logic                add_cout;
    logic                busy;
    logic [1:0]          grant_id;
    logic [CNT_W-1:0]    op_count;
    state_e              state_dbg;

    logic [31:0] op_a [N];
    logic [31:0] op_b [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[32*g +: 32] = op_a[g];
        assign req_b[32*g +: 32] = op_b[g];
    end

    adder_share_ctrl #(.NREQ(N), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .busy      (busy),
        .grant_id  (grant_id),
        .op_count  (op_count),
        .state_dbg (state_dbg)
    );

    // ---------------- shared adder model ----------------
    // Output is the true sum only once the operands have been unchanged for
    // the adder's register depth; otherwise it is corrupted.
    logic [64:0] hist [HD];
    always_ff @(posedge clk) begin
        hist[0] <= {add_cin, add_a, add_b};
        for (int i = 1; i < HD; i++) hist[i] <= hist[i-1];
    end

    always_comb begin
        logic [32:0] full;
        logic        stable;
        full   = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
        stable = 1'b1;
        for (int i = 0; i < HD; i++)
            if (hist[i] !== {add_cin, add_a, add_b}) stable = 1'b0;
        add_sum  = stable ? full[31:0] : (full[31:0] ^ 32'hA5A5_5A5A);
        add_cout = stable ? full[32] : ~full[32];
    end

    // ---------------- scoreboard / model ----------------
    int          n_checks;
    int          n_fail;
    logic [32:0] exp_q [$];
    int          m_ptr;
    int          m_ops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_cin   = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_add", {add_cin, add_a, add_b}, 0);
        check("rst_rsp", {rsp_valid, rsp_cout, rsp_sum}, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant_cnt", {grant_id, op_count}, 0);
        rst_n = 1'b1;
        m_ptr = 0;
        m_ops = 0;
        exp_q.delete();
    endtask

    // Called mid low phase with requests already driven. Runs one full
    // accept / settle / response transaction with bp cycles of backpressure.
    task automatic serve(input int bp, input bit drop, output int win,
                         output logic [31:0] sum, output logic cout);
        int          t;
        int          lat;
        int          exp_w;
        bit          hold_ok;
        logic [31:0] la;
        logic [31:0] lb;
        logic        lc;
        logic [32:0] r;
        win = -1;
        sum = '0;
        cout = 1'b0;
        #1;
        t = 0;
        while (req_ready == '0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (req_ready == '0) begin
            check("accept_timeout", 0, 1);
            return;
        end
        exp_w = model_winner(req_valid, m_ptr);
        for (int i = 0; i < N; i++) if (req_ready[i]) win = i;
        check("ready_onehot", $onehot(req_ready), 1);
        check("winner", win, exp_w);
        la = op_a[win];
        lb = op_b[win];
        lc = req_cin[win];
        r  = {1'b0, la} + {1'b0, lb} + 33'(lc);
        exp_q.push_back(r);
        rsp_ready = (bp > 0) ? ~(N'(1) << win) : '1;

        @(negedge clk);
        if (drop) req_valid[win] = 1'b0;
        #1;
        lat = 1;
        hold_ok = 1'b1;
        while (rsp_valid == '0 && lat < 30) begin
            if (req_ready != '0 || add_a !== la || add_b !== lb || add_cin !== lc || !busy)
                hold_ok = 1'b0;
            @(negedge clk);
            #1;
            lat++;
        end
        check("wait_hold", hold_ok, 1);
        check("latency", lat, SETTLE + 1);
        check("rsp_onehot", rsp_valid, N'(1) << win);
        check("grant_id", grant_id, win);
        r = exp_q.pop_front();
        check("rsp_result", {rsp_cout, rsp_sum}, r);
        sum  = rsp_sum;
        cout = rsp_cout;

        hold_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != (N'(1) << win) || {rsp_cout, rsp_sum} !== r || req_ready != '0)
                hold_ok = 1'b0;
        end
        if (bp > 0) check("bp_hold", hold_ok, 1);
        rsp_ready = '1;
        @(negedge clk);
        #1;
        m_ops++;
        m_ptr = (win + 1) % N;
        check("back_to_idle", {busy, rsp_valid}, 0);
        check("op_count", op_count, m_ops % (1 << CNT_W));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs [4];

    int          win;
    logic [31:0] sum;
    logic        cout;
    int          order [5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        do_reset();

        vecs[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
        vecs[2] = '{0, 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};

        foreach (vecs[v]) begin
            req_valid = '0;
            op_a[vecs[v].req]    = vecs[v].a;
            op_b[vecs[v].req]    = vecs[v].b;
            req_cin[vecs[v].req] = vecs[v].cin;
            req_valid[vecs[v].req] = 1'b1;
            serve(0, 1'b1, win, sum, cout);
            check("tbl_sum", sum, vecs[v].exp_sum);
            check("tbl_cout", cout, vecs[v].exp_cout);
        end

        // Backpressure: 10 cycles of rsp_ready low on the grantee.
        op_a[1] = 32'hDEAD_0000;
        op_b[1] = 32'h0000_BEEF;
        req_cin[1] = 1'b1;
        req_valid = 4'b0010;
        serve(10, 1'b1, win, sum, cout);
        check("bp_sum", sum, 32'hDEAD_BEF0);

        // Reset during the third WAIT cycle drops the op.
        op_a[2] = 32'h0000_0010;
        op_b[2] = 32'h0000_0020;
        req_valid = 4'b0100;
        #1;
        check("rst_test_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {busy, rsp_valid, req_ready, add_cin, add_a, add_b}, 0);
        check("midrst_rsp", {rsp_cout, rsp_sum, grant_id, op_count}, 0);
        begin
            bit no_rsp;
            no_rsp = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (rsp_valid != '0) no_rsp = 1'b0;
            end
            rst_n = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (rsp_valid != '0) no_rsp = 1'b0;
            end
            check("midrst_no_rsp", no_rsp, 1);
        end
        m_ptr = 0;
        m_ops = 0;
        exp_q.delete();
        op_a[3] = 32'h0000_0005;
        op_b[3] = 32'h0000_0007;
        req_cin[3] = 1'b0;
        req_valid = 4'b1000;
        serve(0, 1'b1, win, sum, cout);
        check("post_rst_sum", sum, 32'h0000_000C);

        // All requesters held valid from reset: strict rotation.
        do_reset();
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
            req_cin[i] = 1'($urandom_range(0, 1));
        end
        req_valid = '1;
        for (int j = 0; j < 5; j++) begin
            serve(0, 1'b0, win, sum, cout);
            check("rr_order", win, order[j]);
        end
        req_valid = '0;

        // Random traffic from reset: 17 ops wraps the 4-bit counter to 1.
        do_reset();
        for (int j = 0; j < 17; j++) begin
            for (int i = 0; i < N; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
                req_cin[i] = 1'($urandom_range(0, 1));
            end
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            serve($urandom_range(0, 3), 1'b1, win, sum, cout);
        end
        check("op_count_wrap", op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
